cache_mem_arbiter: RTL and testbench

//  Shares the single word-wide main-memory port between I-cache refills and D-cache refills/writebacks.

---
 rtl/cache_mem_arbiter_pkg.sv | 17 +
 rtl/cache_mem_arbiter_arb_rr2.sv | 27 ++
 rtl/cache_mem_arbiter.sv | 136 +++++++++++++
 tb/tb_cache_mem_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_mem_arbiter_pkg.sv
// cache_mem_arbiter_pkg
//   Shared types for the cache/memory arbiter: FSM state encoding and the
//   1-bit requester identifier used by the round-robin picker and the top.
package cache_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_BURST = 2'd1,
        ARB_DONE  = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

endpackage

// File: rtl/cache_mem_arbiter_arb_rr2.sv
// arb_rr2
//   Combinational 2-requester round-robin picker.
//   Ports:
//     req[1:0]   in   pending requests, bit 0 = I-cache, bit 1 = D-cache
//     last       in   requester granted most recently
//     gnt_valid  out  at least one request pending
//     gnt_id     out  requester to grant
module arb_rr2
    import cache_mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  grant_t     last,
    output logic       gnt_valid,
    output grant_t     gnt_id
);

    always_comb begin
        gnt_valid = |req;
        gnt_id    = GRANT_I;
        if (req == 2'b11) begin
            gnt_id = (last == GRANT_I) ? GRANT_D : GRANT_I;
        end else if (req[1]) begin
            gnt_id = GRANT_D;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
//   Shares one word-wide memory port between I-cache line refills and
//   D-cache line refills/writebacks. Each grant runs a WORDS-beat burst;
//   read beats are assembled into per-requester line buffers.
//   Ports:
//     clk, reset               clock, async active-high reset
//     ic_req/ic_addr           I-cache line read request (level)
//     ic_ack/ic_rline          one-cycle ack, assembled I line
//     dc_req/dc_we/dc_addr     D-cache request, 1 = writeback
//     dc_wline                 writeback line, beat 0 in LSBs
//     dc_ack/dc_rline          one-cycle ack, assembled D read line
//     mem_req/mem_we/mem_addr  beat request to memory, held until mem_ready
//     mem_wdata                write beat data
//     mem_ready/mem_rdata      beat completion and read data
//     gen_stall                pipeline freeze while a miss is outstanding
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int WORDS  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ic_req,
    input  logic [ADDR_W-1:0]         ic_addr,
    output logic                      ic_ack,
    output logic [WORDS*DATA_W-1:0]   ic_rline,
    input  logic                      dc_req,
    input  logic                      dc_we,
    input  logic [ADDR_W-1:0]         dc_addr,
    input  logic [WORDS*DATA_W-1:0]   dc_wline,
    output logic                      dc_ack,
    output logic [WORDS*DATA_W-1:0]   dc_rline,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic                      mem_ready,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic                      gen_stall
);

    localparam int BEAT_W = $clog2(WORDS);
    localparam int BYTE_W = $clog2(DATA_W / 8);
    localparam int OFF_W  = BEAT_W + BYTE_W;

    arb_state_t              state, state_nxt;
    logic [BEAT_W-1:0]       beat;
    grant_t                  gnt;
    grant_t                  last_grant;
    logic [ADDR_W-OFF_W-1:0] line_addr;
    logic                    we;
    logic                    arb_valid;
    grant_t                  arb_id;
    logic                    unused_offsets;

    assign unused_offsets = ^{ic_addr[OFF_W-1:0], dc_addr[OFF_W-1:0]};

    // The ack is registered, so it is seen in the IDLE cycle after DONE; the
    // requester being acked still holds req then and is masked out here.
    arb_rr2 u_rr (
        .req       ({dc_req & ~dc_ack, ic_req & ~ic_ack}),
        .last      (last_grant),
        .gnt_valid (arb_valid),
        .gnt_id    (arb_id)
    );

    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        mem_addr  = {line_addr, beat, {BYTE_W{1'b0}}};
        gen_stall = (ic_req & ~ic_ack) | (dc_req & ~dc_ack);
        case (state)
            ARB_IDLE: begin
                if (arb_valid) state_nxt = ARB_BURST;
            end
            ARB_BURST: begin
                mem_req = 1'b1;
                mem_we  = we;
                if (we) mem_wdata = dc_wline[int'(beat)*DATA_W +: DATA_W];
                if (mem_ready && beat == BEAT_W'(WORDS - 1)) state_nxt = ARB_DONE;
            end
            ARB_DONE: state_nxt = ARB_IDLE;
            default:  state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ARB_IDLE;
            beat       <= '0;
            gnt        <= GRANT_I;
            last_grant <= GRANT_I;
            line_addr  <= '0;
            we         <= 1'b0;
            ic_ack     <= 1'b0;
            dc_ack     <= 1'b0;
            ic_rline   <= '0;
            dc_rline   <= '0;
        end else begin
            state  <= state_nxt;
            ic_ack <= 1'b0;
            dc_ack <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (arb_valid) begin
                        gnt       <= arb_id;
                        beat      <= '0;
                        line_addr <= (arb_id == GRANT_D) ? dc_addr[ADDR_W-1:OFF_W]
                                                         : ic_addr[ADDR_W-1:OFF_W];
                        we        <= (arb_id == GRANT_D) & dc_we;
                    end
                end
                ARB_BURST: begin
                    if (mem_ready) begin
                        if (!we) begin
                            if (gnt == GRANT_D) dc_rline[int'(beat)*DATA_W +: DATA_W] <= mem_rdata;
                            else                ic_rline[int'(beat)*DATA_W +: DATA_W] <= mem_rdata;
                        end
                        beat <= beat + 1'b1;
                    end
                end
                ARB_DONE: begin
                    if (gnt == GRANT_D) dc_ack <= 1'b1;
                    else                ic_ack <= 1'b1;
                    last_grant <= gnt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
module tb_cache_mem_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic         ic_req, dc_req, dc_we;
    logic [31:0]  ic_addr, dc_addr;
    logic [127:0] dc_wline, ic_rline, dc_rline;
    logic         ic_ack, dc_ack;
    logic         mem_req, mem_we, mem_ready, gen_stall;
    logic [31:0]  mem_addr, mem_wdata, mem_rdata;

    typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; } beat_t;
    typedef struct { logic is_d; logic [127:0] line; } ack_t;

    beat_t bq[$];
    ack_t  aq[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int period = 1;
    int wcnt = 0;
    bit stray = 1'b0;

    cache_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WORDS(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .ic_req    (ic_req),
        .ic_addr   (ic_addr),
        .ic_ack    (ic_ack),
        .ic_rline  (ic_rline),
        .dc_req    (dc_req),
        .dc_we     (dc_we),
        .dc_addr   (dc_addr),
        .dc_wline  (dc_wline),
        .dc_ack    (dc_ack),
        .dc_rline  (dc_rline),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .gen_stall (gen_stall)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input logic [127:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got %h expected none", name, act);
    endtask

    function automatic logic [7:0] beat_byte(input logic [1:0] b);
        case (b)
            2'd0:    return 8'h11;
            2'd1:    return 8'h22;
            2'd2:    return 8'h33;
            default: return 8'h44;
        endcase
    endfunction

    // Memory model: ready every `period` cycles of mem_req; optional stray ready when idle.
    always @(negedge clk) begin
        if (mem_req) begin
            if (wcnt >= period - 1) begin
                mem_ready = 1'b1;
                wcnt = 0;
            end else begin
                mem_ready = 1'b0;
                wcnt++;
            end
        end else begin
            mem_ready = stray;
            wcnt = 0;
        end
        mem_rdata = {mem_addr[27:4], beat_byte(mem_addr[3:2])};
    end

    // Monitor: compares every presented beat and every ack against the scoreboard.
    always @(negedge clk) begin
        ack_t a;
        #2;
        if (!reset) begin
            if (mem_req) begin
                if (bq.size() == 0) begin
                    flag("beat_unexpected", 128'(mem_addr));
                end else begin
                    chk("mem_addr", 128'(mem_addr), 128'(bq[0].addr));
                    chk("mem_we", 128'(mem_we), 128'(bq[0].we));
                    if (bq[0].we) chk("mem_wdata", 128'(mem_wdata), 128'(bq[0].wdata));
                    if (mem_ready) void'(bq.pop_front());
                end
            end
            if (ic_ack || dc_ack) begin
                if (aq.size() == 0) begin
                    flag("ack_unexpected", 128'({ic_ack, dc_ack}));
                end else begin
                    a = aq.pop_front();
                    chk("ack_both", 128'(ic_ack & dc_ack), 128'(0));
                    chk("ack_id", 128'(dc_ack), 128'(a.is_d));
                    chk("rline", a.is_d ? dc_rline : ic_rline, a.line);
                end
            end
        end
    end

    task automatic exp_read(input logic [31:0] line, input logic is_d, input logic [127:0] l);
        beat_t b;
        ack_t  a;
        for (int i = 0; i < 4; i++) begin
            b.addr = line + 32'(i * 4);
            b.we = 1'b0;
            b.wdata = '0;
            bq.push_back(b);
        end
        a.is_d = is_d;
        a.line = l;
        aq.push_back(a);
    endtask

    task automatic exp_write(input logic [31:0] line, input logic [127:0] wl, input logic [127:0] old);
        beat_t b;
        ack_t  a;
        for (int i = 0; i < 4; i++) begin
            b.addr = line + 32'(i * 4);
            b.we = 1'b1;
            b.wdata = wl[i*32 +: 32];
            bq.push_back(b);
        end
        a.is_d = 1'b1;
        a.line = old;
        aq.push_back(a);
    endtask

    task automatic do_ic(input logic [31:0] a, input bit stall_chk, output int lat);
        int start;
        bit got;
        got = 1'b0;
        start = cyc;
        ic_addr = a;
        ic_req = 1'b1;
        #1;
        if (stall_chk) chk("stall_first", 128'(gen_stall), 128'(1));
        for (int i = 0; i < 300 && !got; i++) begin
            @(posedge clk); #1;
            if (ic_ack) got = 1'b1;
            else if (stall_chk) chk("stall_wait", 128'(gen_stall), 128'(1));
        end
        lat = cyc - start;
        if (!got) flag("ic_ack_timeout", 128'(lat));
        else if (stall_chk) chk("stall_at_ack", 128'(gen_stall), 128'(0));
        @(posedge clk); #1;
        ic_req = 1'b0;
    endtask

    task automatic do_dc(input logic [31:0] a, input logic w, input logic [127:0] wl, output int lat);
        int start;
        bit got;
        got = 1'b0;
        start = cyc;
        dc_addr = a;
        dc_we = w;
        dc_wline = wl;
        dc_req = 1'b1;
        for (int i = 0; i < 300 && !got; i++) begin
            @(posedge clk); #1;
            if (dc_ack) got = 1'b1;
        end
        lat = cyc - start;
        if (!got) flag("dc_ack_timeout", 128'(lat));
        @(posedge clk); #1;
        dc_req = 1'b0;
        dc_we = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int li, ld, li2, ld2;
        reset = 1'b1;
        ic_req = 1'b0; ic_addr = '0;
        dc_req = 1'b0; dc_we = 1'b0; dc_addr = '0; dc_wline = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ic_ack", 128'(ic_ack), 128'(0));
        chk("rst_dc_ack", 128'(dc_ack), 128'(0));
        chk("rst_mem_req", 128'(mem_req), 128'(0));
        chk("rst_mem_we", 128'(mem_we), 128'(0));
        chk("rst_mem_addr", 128'(mem_addr), 128'(0));
        chk("rst_mem_wdata", 128'(mem_wdata), 128'(0));
        chk("rst_ic_rline", ic_rline, 128'(0));
        chk("rst_dc_rline", dc_rline, 128'(0));
        chk("rst_gen_stall", 128'(gen_stall), 128'(0));
        reset = 1'b0;
        @(posedge clk); #1;

        // 1: I only, ready every cycle, stray ready while idle
        stray = 1'b1;
        exp_read(32'h100, 1'b0, 128'h00001044_00001033_00001022_00001011);
        do_ic(32'h104, 1'b1, li);
        chk("t1_latency", 128'(li), 128'(6));
        stray = 1'b0;
        repeat (2) @(posedge clk); #1;

        // 2: tie, D wins, I follows one cycle after dc_ack
        exp_read(32'h200, 1'b1, 128'h00002044_00002033_00002022_00002011);
        exp_read(32'h600, 1'b0, 128'h00006044_00006033_00006022_00006011);
        fork
            do_dc(32'h200, 1'b0, '0, ld);
            do_ic(32'h600, 1'b1, li);
        join
        chk("t2_d_latency", 128'(ld), 128'(6));
        chk("t2_i_latency", 128'(li), 128'(12));
        repeat (2) @(posedge clk); #1;

        // 3: continuous re-requests alternate D,I,D,I
        exp_read(32'h300, 1'b1, 128'h00003044_00003033_00003022_00003011);
        exp_read(32'h400, 1'b0, 128'h00004044_00004033_00004022_00004011);
        exp_read(32'h340, 1'b1, 128'h00003444_00003433_00003422_00003411);
        exp_read(32'h440, 1'b0, 128'h00004444_00004433_00004422_00004411);
        fork
            begin do_dc(32'h300, 1'b0, '0, ld); do_dc(32'h340, 1'b0, '0, ld2); end
            begin do_ic(32'h400, 1'b0, li); do_ic(32'h440, 1'b0, li2); end
        join
        chk("t3_d2_latency", 128'(ld2), 128'(11));
        chk("t3_i2_latency", 128'(li2), 128'(11));
        repeat (2) @(posedge clk); #1;

        // 4: writeback, ready every 3rd cycle, dc_rline keeps the last D read line
        period = 3;
        exp_write(32'h500, {32'hD, 32'hC, 32'hB, 32'hA},
                  128'h00003444_00003433_00003422_00003411);
        do_dc(32'h508, 1'b1, {32'hD, 32'hC, 32'hB, 32'hA}, ld);
        chk("t4_latency", 128'(ld), 128'(14));
        period = 1;
        repeat (2) @(posedge clk); #1;

        // 5: reset after beat 1 of an I read
        begin
            beat_t b;
            b.we = 1'b0; b.wdata = '0;
            b.addr = 32'h700; bq.push_back(b);
            b.addr = 32'h704; bq.push_back(b);
        end
        ic_addr = 32'h700;
        ic_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("t5_mem_req", 128'(mem_req), 128'(0));
        chk("t5_ic_ack", 128'(ic_ack), 128'(0));
        chk("t5_mem_addr", 128'(mem_addr), 128'(0));
        chk("t5_ic_rline", ic_rline, 128'(0));
        ic_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("t5_idle", 128'(mem_req), 128'(0));

        // 6: read data assembly, beat 0 in LSBs
        exp_read(32'h000, 1'b0, 128'h00000044_00000033_00000022_00000011);
        do_ic(32'h008, 1'b0, li);
        chk("t6_latency", 128'(li), 128'(6));

        repeat (5) @(posedge clk); #1;
        chk("beatq_drained", 128'(bq.size()), 128'(0));
        chk("ackq_drained", 128'(aq.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
